// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and default sizing for the pipelined ALU.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int OPCODE_WIDTH  = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROTL = 4'd6,
        OP_ROTR = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_div.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH iterations per divide.
module alu_div #(
    parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_next;

    // Dividend bits leave the top of quo_q while quotient bits enter at the bottom.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, div_q});
        rem_next = fits ? WIDTH'(shifted - {1'b0, div_q}) : shifted[WIDTH-1:0];
    end

    // done marks the last iteration, so quotient already includes the final bit.
    assign quotient = {quo_q[WIDTH-2:0], fits};
    assign done     = busy && (count == CW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy  <= 1'b0;
            count <= '0;
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CW'(WIDTH);
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
        end else if (busy) begin
            rem_q <= rem_next;
            quo_q <= quotient;
            count <= count - CW'(1);
            busy  <= (count != CW'(1));
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU: single-cycle ops land in the result registers directly,
// non-zero divides go through the iterative divider first.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OPW   = OPCODE_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    input  logic [OPW-1:0]   io_ALU_Sel,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_ALU_Out,
    output logic             io_CarryOut,
    output logic             io_Zero,
    output logic             io_DivErr
);

    alu_state_e         state;
    logic               ready_en;
    alu_op_e            op;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_err;
    logic               accept;
    logic               deliver;
    logic               div_start;
    logic               div_done;
    logic [WIDTH-1:0]   div_quotient;

    always_comb begin
        op        = alu_op_e'(io_ALU_Sel);
        sum       = {1'b0, io_A} + {1'b0, io_B};
        diff      = {1'b0, io_A} - {1'b0, io_B};
        prod      = {{WIDTH{1'b0}}, io_A} * {{WIDTH{1'b0}}, io_B};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = sum[WIDTH-1:0];   alu_carry = sum[WIDTH];  end
            OP_SUB:  begin alu_res = diff[WIDTH-1:0];  alu_carry = diff[WIDTH]; end
            OP_MUL:  begin alu_res = prod[WIDTH-1:0];  alu_carry = |prod[2*WIDTH-1:WIDTH]; end
            // Only a divide by zero is taken from here; real divides use the divider.
            OP_DIV:  begin alu_res = '1; alu_err = 1'b1; end
            OP_SHL:  alu_res = {io_A[WIDTH-2:0], 1'b0};
            OP_SHR:  alu_res = {1'b0, io_A[WIDTH-1:1]};
            OP_ROTL: alu_res = {io_A[WIDTH-2:0], io_A[WIDTH-1]};
            OP_ROTR: alu_res = {io_A[0], io_A[WIDTH-1:1]};
            OP_AND:  alu_res = io_A & io_B;
            OP_OR:   alu_res = io_A | io_B;
            OP_XOR:  alu_res = io_A ^ io_B;
            OP_NOR:  alu_res = ~(io_A | io_B);
            OP_NAND: alu_res = ~(io_A & io_B);
            OP_XNOR: alu_res = ~(io_A ^ io_B);
            OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (io_A > io_B)};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (io_A == io_B)};
            default: alu_res = '0;
        endcase
    end

    // ready_en keeps in_ready low during reset and until the first edge after release.
    assign io_in_ready  = ready_en && ((state == ST_IDLE) || ((state == ST_HOLD) && io_out_ready));
    assign io_out_valid = (state == ST_HOLD);
    assign accept       = io_in_valid && io_in_ready;
    assign deliver      = io_out_valid && io_out_ready;
    assign div_start    = accept && (op == OP_DIV) && (io_B != '0);

    alu_div #(.WIDTH(WIDTH)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (io_A),
        .divisor  (io_B),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // A transfer in from HOLD implies a transfer out, so IDLE and HOLD share the accept path.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ready_en    <= 1'b0;
            io_ALU_Out  <= '0;
            io_CarryOut <= 1'b0;
            io_Zero     <= 1'b0;
            io_DivErr   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (div_start) begin
                            state <= ST_DIV;
                        end else begin
                            state       <= ST_HOLD;
                            io_ALU_Out  <= alu_res;
                            io_CarryOut <= alu_carry;
                            io_Zero     <= (alu_res == '0);
                            io_DivErr   <= alu_err;
                        end
                    end else if (deliver) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state       <= ST_HOLD;
                        io_ALU_Out  <= div_quotient;
                        io_CarryOut <= 1'b0;
                        io_Zero     <= (div_quotient == '0);
                        io_DivErr   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, corner sequences, random scoreboard.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] io_A = '0;
    logic [W-1:0] io_B = '0;
    logic [3:0]   io_ALU_Sel = '0;
    logic         io_in_valid = 1'b0;
    logic         io_in_ready;
    logic         io_out_valid;
    logic         io_out_ready = 1'b0;
    logic [W-1:0] io_ALU_Out;
    logic         io_CarryOut;
    logic         io_Zero;
    logic         io_DivErr;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    alu_pipe #(.WIDTH(W), .OPW(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_A         (io_A),
        .io_B         (io_B),
        .io_ALU_Sel   (io_ALU_Sel),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_ALU_Out   (io_ALU_Out),
        .io_CarryOut  (io_CarryOut),
        .io_Zero      (io_Zero),
        .io_DivErr    (io_DivErr)
    );

    typedef struct {
        logic [7:0] res;
        logic       carry;
        logic       err;
    } result_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic       carry;
        logic       zero;
        logic       err;
        int         lat;
    } vec_t;

    // Reference model in plain integer arithmetic on the opcode table.
    function automatic result_t refModel(input int op, input int a, input int b);
        result_t r;
        int v;
        v = 0;
        r.carry = 1'b0;
        r.err = 1'b0;
        case (op)
            0:  begin v = a + b; r.carry = (v > 255); end
            1:  begin v = a - b; r.carry = (a < b); if (v < 0) v = v + 256; end
            2:  begin v = a * b; r.carry = (v > 255); end
            3:  if (b == 0) begin v = 255; r.err = 1'b1; end else v = a / b;
            4:  v = a * 2;
            5:  v = a / 2;
            6:  v = a * 2 + a / 128;
            7:  v = a / 2 + (a % 2) * 128;
            8:  v = a & b;
            9:  v = a | b;
            10: v = a ^ b;
            11: v = ~(a | b);
            12: v = ~(a & b);
            13: v = ~(a ^ b);
            14: v = (a > b) ? 1 : 0;
            default: v = (a == b) ? 1 : 0;
        endcase
        r.res = 8'(v);
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] out, input logic c, input logic z,
                                input logic e, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.out = out;
        v.carry = c; v.zero = z; v.err = e; v.lat = lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic valid, input logic outReady);
        io_ALU_Sel   = op;
        io_A         = a;
        io_B         = b;
        io_in_valid  = valid;
        io_out_ready = outReady;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int   lat;
        logic sawReady;
        string tag;
        tag = $sformatf("vec%0d", idx);
        applyStimulus(v.op, v.a, v.b, 1'b1, 1'b1);
        #1;
        checkOutput({tag, "_in_ready"}, 32'(io_in_ready), 32'd1);
        tick();
        io_in_valid = 1'b0;
        io_A = ~v.a;
        io_B = ~v.b;
        lat = 1;
        sawReady = 1'b0;
        while (!io_out_valid && lat < 40) begin
            if (io_in_ready) sawReady = 1'b1;
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(v.lat));
        checkOutput({tag, "_busy_ready"}, 32'(sawReady), 32'd0);
        checkOutput({tag, "_out"}, 32'(io_ALU_Out), 32'(v.out));
        checkOutput({tag, "_carry"}, 32'(io_CarryOut), 32'(v.carry));
        checkOutput({tag, "_zero"}, 32'(io_Zero), 32'(v.zero));
        checkOutput({tag, "_diverr"}, 32'(io_DivErr), 32'(v.err));
        tick();
        checkOutput({tag, "_valid_drop"}, 32'(io_out_valid), 32'd0);
    endtask

    // Random-phase scoreboard state.
    result_t q[$];
    result_t pending;
    logic    prevAccept = 1'b0;
    logic    prevDeliver = 1'b0;

    task automatic scoreboardStep();
        if (prevDeliver && q.size() > 0) void'(q.pop_front());
        if (prevAccept) q.push_back(pending);
        if (io_out_valid) begin
            if (q.size() == 0) begin
                checkOutput("rnd_spurious_valid", 32'(io_out_valid), 32'd0);
            end else begin
                checkOutput("rnd_out", 32'(io_ALU_Out), 32'(q[0].res));
                checkOutput("rnd_carry", 32'(io_CarryOut), 32'(q[0].carry));
                checkOutput("rnd_diverr", 32'(io_DivErr), 32'(q[0].err));
                checkOutput("rnd_zero", 32'(io_Zero), 32'(q[0].res == 8'h00));
            end
        end
        if (q.size() > 1) checkOutput("rnd_depth", 32'(q.size()), 32'd1);
    endtask

    vec_t vecs[18];

    initial begin
        logic   flag;
        int     op;
        int     a;
        int     b;

        vecs[0]  = mk(4'd0,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1);
        vecs[1]  = mk(4'd3,  8'd200, 8'd7, 8'd28, 1'b0, 1'b0, 1'b0, 9);
        vecs[2]  = mk(4'd3,  8'h05, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1);
        vecs[3]  = mk(4'd1,  8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1);
        vecs[4]  = mk(4'd2,  8'd16, 8'd17, 8'h10, 1'b1, 1'b0, 1'b0, 1);
        vecs[5]  = mk(4'd15, 8'h09, 8'h09, 8'h01, 1'b0, 1'b0, 1'b0, 1);
        vecs[6]  = mk(4'd14, 8'h03, 8'h09, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        vecs[7]  = mk(4'd11, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        vecs[8]  = mk(4'd6,  8'h81, 8'h55, 8'h03, 1'b0, 1'b0, 1'b0, 1);
        vecs[9]  = mk(4'd7,  8'h01, 8'h55, 8'h80, 1'b0, 1'b0, 1'b0, 1);
        vecs[10] = mk(4'd3,  8'd100, 8'd3, 8'd33, 1'b0, 1'b0, 1'b0, 9);
        vecs[11] = mk(4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        vecs[12] = mk(4'd5,  8'h81, 8'h55, 8'h40, 1'b0, 1'b0, 1'b0, 1);
        vecs[13] = mk(4'd12, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        vecs[14] = mk(4'd3,  8'hFF, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 9);
        vecs[15] = mk(4'd13, 8'hA5, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        vecs[16] = mk(4'd2,  8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1);
        vecs[17] = mk(4'd4,  8'h81, 8'h55, 8'h02, 1'b0, 1'b0, 1'b0, 1);

        // Power-on reset, released mid-cycle.
        #1 reset = 1'b0;
        #2;
        checkOutput("rst_in_ready", 32'(io_in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(io_out_valid), 32'd0);
        checkOutput("rst_out", 32'(io_ALU_Out), 32'd0);
        checkOutput("rst_carry", 32'(io_CarryOut), 32'd0);
        checkOutput("rst_zero", 32'(io_Zero), 32'd0);
        checkOutput("rst_diverr", 32'(io_DivErr), 32'd0);
        tick();
        tick();
        checkOutput("rst_in_ready_held", 32'(io_in_ready), 32'd0);
        #2 reset = 1'b1;
        tick();
        checkOutput("rst_release_ready", 32'(io_in_ready), 32'd1);

        foreach (vecs[i]) runVector(vecs[i], i);

        // Back-to-back sub, mul, eq with the consumer always ready.
        applyStimulus(4'd1, 8'd3, 8'd5, 1'b1, 1'b1);
        tick();
        applyStimulus(4'd2, 8'd16, 8'd17, 1'b1, 1'b1);
        checkOutput("b2b_sub_valid", 32'(io_out_valid), 32'd1);
        checkOutput("b2b_sub_out", 32'(io_ALU_Out), 32'hFE);
        checkOutput("b2b_sub_carry", 32'(io_CarryOut), 32'd1);
        tick();
        applyStimulus(4'd15, 8'd9, 8'd9, 1'b1, 1'b1);
        checkOutput("b2b_mul_valid", 32'(io_out_valid), 32'd1);
        checkOutput("b2b_mul_out", 32'(io_ALU_Out), 32'h10);
        checkOutput("b2b_mul_carry", 32'(io_CarryOut), 32'd1);
        tick();
        io_in_valid = 1'b0;
        checkOutput("b2b_eq_valid", 32'(io_out_valid), 32'd1);
        checkOutput("b2b_eq_out", 32'(io_ALU_Out), 32'h01);
        checkOutput("b2b_eq_zero", 32'(io_Zero), 32'd0);
        tick();
        checkOutput("b2b_drain", 32'(io_out_valid), 32'd0);

        // Stalled consumer: result held, new requests ignored.
        applyStimulus(4'd2, 8'd3, 8'd3, 1'b1, 1'b0);
        tick();
        applyStimulus(4'd0, 8'h77, 8'h66, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", 32'(io_out_valid), 32'd1);
            checkOutput("stall_out", 32'(io_ALU_Out), 32'h09);
            checkOutput("stall_carry", 32'(io_CarryOut), 32'd0);
            checkOutput("stall_in_ready", 32'(io_in_ready), 32'd0);
            tick();
        end
        io_in_valid = 1'b0;
        io_out_ready = 1'b1;
        #1;
        checkOutput("stall_release_ready", 32'(io_in_ready), 32'd1);
        tick();
        checkOutput("stall_delivered", 32'(io_out_valid), 32'd0);
        tick();
        checkOutput("stall_no_extra", 32'(io_out_valid), 32'd0);

        // Reset in the middle of a divide discards it.
        applyStimulus(4'd3, 8'd100, 8'd3, 1'b1, 1'b1);
        tick();
        io_in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(io_out_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(io_in_ready), 32'd0);
        checkOutput("mid_rst_out", 32'(io_ALU_Out), 32'd0);
        tick();
        #2 reset = 1'b1;
        tick();
        checkOutput("mid_rst_release_ready", 32'(io_in_ready), 32'd1);
        flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (io_out_valid) flag = 1'b1;
            tick();
        end
        checkOutput("mid_rst_no_result", 32'(flag), 32'd0);

        // Random traffic with random stalls against the reference model.
        prevAccept = 1'b0;
        prevDeliver = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            scoreboardStep();
            op = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
            applyStimulus(4'(op), 8'(a), 8'(b), ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 3) != 0));
            pending = refModel(op, a, b);
            #1;
            prevAccept  = io_in_valid && io_in_ready;
            prevDeliver = io_out_valid && io_out_ready;
            @(posedge clock);
            #1;
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            scoreboardStep();
            io_in_valid = 1'b0;
            io_out_ready = 1'b1;
            #1;
            prevAccept  = 1'b0;
            prevDeliver = io_out_valid && io_out_ready;
            @(posedge clock);
            #1;
        end
        checkOutput("rnd_drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 4..32.
REQ-002 Parameter OPW, default 4, opcode width; fixed at 4 for this generation.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted at 0.
REQ-005 io_A  input  WIDTH  operand A, unsigned.
REQ-006 io_B  input  WIDTH  operand B, unsigned.
REQ-007 io_ALU_Sel  input  OPW  opcode, sampled with the operands on acceptance.
REQ-008 io_in_valid  input  1  operand/opcode set is valid.
REQ-009 io_in_ready  output  1  block can accept an operand set this cycle.
REQ-010 io_out_valid  output  1  result registers hold an undelivered result.
REQ-011 io_out_ready  input  1  consumer takes the result this cycle.
REQ-012 io_ALU_Out  output  WIDTH  result.
REQ-013 io_CarryOut  output  1  carry/borrow/overflow flag.
REQ-014 io_Zero  output  1  1 when io_ALU_Out is all zeros.
REQ-015 io_DivErr  output  1  1 when the result comes from a divide by zero.

Function
REQ-016 Opcodes SHALL be: 0 add, 1 sub, 2 mul (low WIDTH bits), 3 div (quotient), 4 shl by 1, 5 shr by 1, 6 rotl by 1, 7 rotr by 1, 8 and, 9 or, 10 xor, 11 nor, 12 nand, 13 xnor, 14 gt (1 if A>B unsigned), 15 eq (1 if A==B); compare results are zero-extended.
REQ-017 io_CarryOut SHALL be: add, carry out of bit WIDTH-1; sub, 1 when A<B (borrow); mul, 1 when the upper WIDTH bits of the full product are nonzero; all other ops, 0.
REQ-018 A transfer in SHALL occur when io_in_valid and io_in_ready are both 1 on a clock edge; a transfer out SHALL occur when io_out_valid and io_out_ready are both 1.
REQ-019 The FSM SHALL have states IDLE, DIV and HOLD.
REQ-020 IDLE: io_in_ready=1. A non-div transfer in -> HOLD. A div transfer in with B!=0 -> DIV. A div transfer in with B==0 -> HOLD.
REQ-021 DIV: io_in_ready=0; one quotient bit per cycle by restoring division; after WIDTH cycles, register the result and go to HOLD.
REQ-022 HOLD: io_out_valid=1. io_in_ready=io_out_ready. A transfer out with no transfer in -> IDLE. A transfer out together with a transfer in follows the IDLE transitions for the new op.
REQ-023 Latency from transfer in to io_out_valid SHALL be 1 cycle for non-div ops and for divide by zero, and WIDTH+1 cycles for div with B!=0.
REQ-024 Non-div ops SHALL sustain one result per cycle while io_out_ready is held at 1.
REQ-025 Divide by zero SHALL give io_ALU_Out all ones, io_DivErr=1, io_CarryOut=0; io_DivErr SHALL be 0 for all other results.
REQ-026 io_ALU_Out and all flags SHALL stay stable while io_out_valid=1 and io_out_ready=0.
REQ-027 Operands and opcode SHALL be captured at transfer in; input changes after that SHALL NOT affect the result.
REQ-028 io_in_valid asserted while io_in_ready=0 SHALL be ignored, with no capture.

Reset
REQ-029 When reset is asserted, the block SHALL go to IDLE immediately, independent of clock.
REQ-030 On reset: io_out_valid=0, io_ALU_Out=0, io_CarryOut=0, io_Zero=0, io_DivErr=0, divider state cleared.
REQ-031 A reset during DIV or HOLD SHALL discard the operation in flight; no result SHALL be produced for it after reset is released.
REQ-032 While reset is asserted, io_in_ready SHALL be 0; it SHALL be 1 from the first clock edge after reset is released.

Structure
REQ-033 Package alu_pkg SHALL hold the opcode enum, the FSM state enum and the default WIDTH constant.
REQ-034 Sub-module alu_div SHALL implement the WIDTH-cycle iterative divider, with start/done handshake and quotient output.
REQ-035 All other operations SHALL be single-cycle combinational logic inside alu_pipe, feeding the result registers.

Verification (WIDTH=8)
REQ-036 add A=0xF0, B=0x20, out_ready=1 -> next cycle Out=0x10, Carry=1, Zero=0, out_valid for exactly 1 cycle.
REQ-037 div A=200, B=7 -> out_valid on cycle 9 after acceptance, Out=28, in_ready=0 during cycles 1-8.
REQ-038 div A=5, B=0 -> 1 cycle later Out=0xFF, DivErr=1, Carry=0.
REQ-039 Back-to-back sub 3-5, mul 16*17, eq 9==9 with out_ready=1 -> Out 0xFE/Carry=1, then 0x10/Carry=1, then 0x01/Zero=0 on consecutive cycles.
REQ-040 mul 3*3 with out_ready=0 for 5 cycles -> Out=0x09 held stable, in_ready=0 until out_ready rises.
REQ-041 Reset asserted at cycle 4 of div 100/3 -> out_valid=0 at once, no result after release, in_ready=1 from the first edge after release.
